// File: rtl/mushroom_line_fetcher_pkg.sv
// rtl/mushroom_line_fetcher_pkg.sv - shared types and constants for the mushroom line fetcher
//
// Purpose : sprite geometry, line-buffer slot type and fetch FSM encoding
//           used by mushroom_line_fetcher and mushroom_slot_match.
// Ports   : none (package)
package mushroom_pkg;

   localparam int SPR_W   = 16;
   localparam int SPR_H   = 16;
   localparam int COORD_W = 10;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CHECK = 2'd1;
   localparam logic [1:0] ST_LOAD  = 2'd2;
   localparam logic [1:0] ST_SWAP  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      CHECK = ST_CHECK,
      LOAD  = ST_LOAD,
      SWAP  = ST_SWAP
   } fetch_state_t;

   typedef struct packed {
      logic               valid;
      logic [COORD_W-1:0] x;
      logic [SPR_W-1:0]   row;
      logic               flip;
   } slot_t;

   localparam slot_t SLOT_EMPTY = '0;

   // Coordinates are widened by one bit so that a < b shows up in the MSB
   // instead of wrapping back into the 0..15 sprite window.
   function automatic logic [COORD_W:0] coord_diff(input logic [COORD_W-1:0] a,
                                                   input logic [COORD_W-1:0] b);
      return {1'b0, a} - {1'b0, b};
   endfunction

endpackage

// File: rtl/mushroom_line_fetcher_slot_match.sv
// rtl/mushroom_line_fetcher_slot_match.sv - per-slot pixel hit test against draw_x
//
// Purpose : decides whether one line-buffer slot covers the current pixel.
// Ports   : slot    in  slot_t  displayed slot (valid, x, row, flip)
//           draw_x  in  10      current pixel x
//           hit     out 1       combinational hit for this slot
module mushroom_slot_match
   import mushroom_pkg::*;
(
   input  slot_t              slot,
   input  logic [COORD_W-1:0] draw_x,
   output logic               hit
);

   logic [COORD_W:0] dx;
   logic [3:0]       col;

   always_comb begin
      dx  = coord_diff(draw_x, slot.x);
      // 15-dx equals ~dx in 4 bits; xor with flip selects dx for mirrored slots.
      col = ~dx[3:0] ^ {4{slot.flip}};
      hit = slot.valid
            && (draw_x >= slot.x)
            && (dx <= (COORD_W+1)'(SPR_W-1))
            && slot.row[col];
   end

endmodule

// File: rtl/mushroom_line_fetcher.sv
// rtl/mushroom_line_fetcher.sv - per-scanline mushroom sprite scheduler and pixel hit generator
//
// Purpose : on new_line, scans NUM_OBJ objects, fetches ROM rows of those on next_y
//           into a work buffer (up to MAX_PER_LINE), then swaps it into the display
//           buffer used to produce is_mushroom during active video.
// Ports   : Clk, Reset (sync, active high)
//           new_line, next_y          line fetch request and target scanline
//           obj_valid, obj_x, obj_y   packed object table, obj 0 in LSBs
//           obj_flip                  per-object horizontal mirror (MUSHROOM_FLIP_EN only)
//           rom_addr / rom_data       shared sprite ROM row address and row data
//           draw_x, is_mushroom       current pixel x and registered hit
//           fetch_busy, line_ovf      fetch in progress, last line overflowed
// Config  : MUSHROOM_FLIP_EN enables obj_flip and per-slot mirroring.
module mushroom_line_fetcher
   import mushroom_pkg::*;
#(
   parameter int NUM_OBJ      = 8,
   parameter int MAX_PER_LINE = 4
)(
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic                       new_line,
   input  logic [COORD_W-1:0]         next_y,
   input  logic [NUM_OBJ-1:0]         obj_valid,
   input  logic [NUM_OBJ*COORD_W-1:0] obj_x,
   input  logic [NUM_OBJ*COORD_W-1:0] obj_y,
`ifdef MUSHROOM_FLIP_EN
   input  logic [NUM_OBJ-1:0]         obj_flip,
`endif
   output logic [3:0]                 rom_addr,
   input  logic [SPR_W-1:0]           rom_data,
   input  logic [COORD_W-1:0]         draw_x,
   output logic                       is_mushroom,
   output logic                       fetch_busy,
   output logic                       line_ovf
);

   localparam int IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
   localparam int CNT_W = $clog2(MAX_PER_LINE + 1);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_OBJ - 1);
   localparam logic [CNT_W-1:0] SLOT_LIMIT = CNT_W'(MAX_PER_LINE);

   fetch_state_t       state;
   logic [IDX_W-1:0]   idx;
   logic [COORD_W-1:0] line_y;
   logic [CNT_W-1:0]   work_cnt;
   logic               ovf_work;

   slot_t work_buf [MAX_PER_LINE];
   slot_t disp_buf [MAX_PER_LINE];

   logic [COORD_W-1:0] cur_x;
   logic [COORD_W-1:0] cur_y;
   logic               cur_flip;
   logic [COORD_W:0]   dy;
   logic               obj_hit;
   logic               slot_free;
   logic               last_obj;
   logic [MAX_PER_LINE-1:0] slot_hit;

   always_comb begin
      cur_x     = obj_x[idx*COORD_W +: COORD_W];
      cur_y     = obj_y[idx*COORD_W +: COORD_W];
`ifdef MUSHROOM_FLIP_EN
      cur_flip  = obj_flip[idx];
`else
      cur_flip  = 1'b0;
`endif
      dy        = coord_diff(line_y, cur_y);
      obj_hit   = obj_valid[idx] && (line_y >= cur_y) && (dy <= (COORD_W+1)'(SPR_H-1));
      slot_free = work_cnt < SLOT_LIMIT;
      last_obj  = idx == LAST_IDX;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state       <= IDLE;
         idx         <= '0;
         line_y      <= '0;
         work_cnt    <= '0;
         ovf_work    <= 1'b0;
         rom_addr    <= '0;
         fetch_busy  <= 1'b0;
         line_ovf    <= 1'b0;
         is_mushroom <= 1'b0;
         for (int s = 0; s < MAX_PER_LINE; s++) begin
            work_buf[s] <= SLOT_EMPTY;
            disp_buf[s] <= SLOT_EMPTY;
         end
      end else begin
         is_mushroom <= |slot_hit;

         case (state)
            CHECK: begin
               if (obj_hit && slot_free) begin
                  rom_addr <= dy[3:0];
                  state    <= LOAD;
               end else begin
                  if (obj_hit)
                     ovf_work <= 1'b1;
                  if (last_obj)
                     state <= SWAP;
                  else
                     idx <= idx + 1'b1;
               end
            end
            LOAD: begin
               // rom_data now reflects the rom_addr registered in CHECK.
               for (int s = 0; s < MAX_PER_LINE; s++) begin
                  if (CNT_W'(s) == work_cnt)
                     work_buf[s] <= '{valid: 1'b1, x: cur_x, row: rom_data, flip: cur_flip};
               end
               work_cnt <= work_cnt + 1'b1;
               if (last_obj) begin
                  state <= SWAP;
               end else begin
                  idx   <= idx + 1'b1;
                  state <= CHECK;
               end
            end
            SWAP: begin
               for (int s = 0; s < MAX_PER_LINE; s++)
                  disp_buf[s] <= work_buf[s];
               line_ovf   <= ovf_work;
               fetch_busy <= 1'b0;
               state      <= IDLE;
            end
            default: ;
         endcase

         // A new_line always (re)starts the scan; placed last so it overrides any
         // in-flight CHECK/LOAD update. The display buffer is only written by SWAP.
         if (new_line) begin
            state      <= CHECK;
            idx        <= '0;
            line_y     <= next_y;
            work_cnt   <= '0;
            ovf_work   <= 1'b0;
            fetch_busy <= 1'b1;
            for (int s = 0; s < MAX_PER_LINE; s++)
               work_buf[s] <= SLOT_EMPTY;
         end
      end
   end

   for (genvar g = 0; g < MAX_PER_LINE; g++) begin : g_slot
      mushroom_slot_match u_match (
         .slot   (disp_buf[g]),
         .draw_x (draw_x),
         .hit    (slot_hit[g])
      );
   end

endmodule

// File: tb/tb_mushroom_line_fetcher.sv
// tb/tb_mushroom_line_fetcher.sv - self-checking bench for mushroom_line_fetcher
module tb_mushroom_line_fetcher;

   localparam int N = 8;
   localparam int M = 4;

   logic           Clk = 1'b0;
   logic           Reset;
   logic           new_line;
   logic [9:0]     next_y;
   logic [9:0]     draw_x;
   logic [N-1:0]   obj_valid;
   logic [N*10-1:0] obj_x;
   logic [N*10-1:0] obj_y;
`ifdef MUSHROOM_FLIP_EN
   logic [N-1:0]   obj_flip;
`endif
   logic [3:0]     rom_addr;
   logic [15:0]    rom_data;
   logic           is_mushroom;
   logic           fetch_busy;
   logic           line_ovf;

   logic [15:0] rom [16];
   int  ox [N];
   int  oy [N];
   bit  ov [N];
   bit  ofl [N];
   int  vectors = 0;
   int  errors  = 0;
   int  disp_y  = 0;
   bit  disp_ok = 0;

   always #5 Clk = ~Clk;

   assign rom_data = rom[rom_addr];

   always_comb begin
      obj_valid = '0;
      obj_x     = '0;
      obj_y     = '0;
      for (int k = 0; k < N; k++) begin
         obj_valid[k]      = ov[k];
         obj_x[k*10 +: 10] = 10'(ox[k]);
         obj_y[k*10 +: 10] = 10'(oy[k]);
      end
   end

`ifdef MUSHROOM_FLIP_EN
   always_comb begin
      obj_flip = '0;
      for (int k = 0; k < N; k++)
         obj_flip[k] = ofl[k];
   end
`endif

   mushroom_line_fetcher #(.NUM_OBJ(N), .MAX_PER_LINE(M)) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .new_line    (new_line),
      .next_y      (next_y),
      .obj_valid   (obj_valid),
      .obj_x       (obj_x),
      .obj_y       (obj_y),
`ifdef MUSHROOM_FLIP_EN
      .obj_flip    (obj_flip),
`endif
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .draw_x      (draw_x),
      .is_mushroom (is_mushroom),
      .fetch_busy  (fetch_busy),
      .line_ovf    (line_ovf)
   );

   // Reference: which objects a line selects, and what a pixel shows.
   function automatic bit obj_on_line(int o, int y);
      return ov[o] && (y >= oy[o]) && (y - oy[o] <= 15);
   endfunction

   function automatic bit model_ovf(int y);
      int cnt = 0;
      for (int o = 0; o < N; o++)
         if (obj_on_line(o, y)) cnt++;
      return cnt > M;
   endfunction

   function automatic bit model_hit(int x);
      int cnt = 0;
      int dx, col;
      if (!disp_ok) return 0;
      for (int o = 0; o < N; o++) begin
         if (obj_on_line(o, disp_y) && cnt < M) begin
            cnt++;
            dx = x - ox[o];
            if (dx >= 0 && dx <= 15) begin
               col = ofl[o] ? dx : 15 - dx;
               if (rom[disp_y - oy[o]][col]) return 1;
            end
         end
      end
      return 0;
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start_fetch(input int y);
      next_y   = 10'(y);
      new_line = 1'b1;
      tick();
      new_line = 1'b0;
   endtask

   // n = clock edges already elapsed since the new_line edge (inclusive).
   task automatic wait_swap(input int y, input int n0);
      int n = n0;
      while (fetch_busy === 1'b1 && n < 40) begin
         tick();
         n++;
      end
      check("fetch_done", {31'd0, fetch_busy}, 0);
      check("latency_le_17", (n <= 17) ? 1 : 0, 1);
      check("line_ovf", {31'd0, line_ovf}, {31'd0, model_ovf(y)});
      disp_y  = y;
      disp_ok = 1;
   endtask

   task automatic fetch(input int y);
      start_fetch(y);
      wait_swap(y, 1);
   endtask

   task automatic sweep(input int lo, input int hi, input string tag);
      for (int x = lo; x <= hi; x++) begin
         draw_x = 10'(x);
         tick();
         check(tag, {31'd0, is_mushroom}, {31'd0, model_hit(x)});
      end
   endtask

   task automatic clear_objs();
      for (int k = 0; k < N; k++) begin
         ov[k] = 0; ox[k] = 0; oy[k] = 0; ofl[k] = 0;
      end
   endtask

   initial begin
      for (int r = 0; r < 16; r++) rom[r] = 16'($urandom);
      rom[3] = 16'hA5C3;
      clear_objs();
      Reset = 1'b1; new_line = 1'b0; next_y = '0; draw_x = '0;
      tick(); tick();
      check("rst_rom_addr", {28'd0, rom_addr}, 0);
      check("rst_is_mushroom", {31'd0, is_mushroom}, 0);
      check("rst_fetch_busy", {31'd0, fetch_busy}, 0);
      check("rst_line_ovf", {31'd0, line_ovf}, 0);
      Reset = 1'b0;
      tick();
      sweep(0, 20, "empty_display");

      // Single object, row 3.
      ov[0] = 1; ox[0] = 100; oy[0] = 50;
      start_fetch(53);
      check("busy_after_new_line", {31'd0, fetch_busy}, 1);
      tick();
      check("rom_addr_row3", {28'd0, rom_addr}, 3);
      wait_swap(53, 2);
      sweep(96, 120, "single_obj");

      // Lines just above and just below the sprite.
      fetch(49);
      check("rom_addr_kept_49", {28'd0, rom_addr}, 3);
      sweep(96, 120, "line_above");
      fetch(66);
      check("rom_addr_kept_66", {28'd0, rom_addr}, 3);
      sweep(96, 120, "line_below");

      // Six objects on one line: four slots, overflow flagged.
      for (int k = 0; k < 6; k++) begin
         ov[k] = 1; ox[k] = 10 + 40 * k; oy[k] = 20;
      end
      fetch(20);
      check("ovf_six_objs", {31'd0, line_ovf}, 1);
      sweep(0, 260, "six_objs");
      for (int k = 1; k < 6; k++) oy[k] = 200;
      fetch(25);
      check("ovf_cleared", {31'd0, line_ovf}, 0);
      sweep(0, 60, "one_obj_after_ovf");

      // Restart 5 cycles into a fetch; display holds line 25 meanwhile.
      oy[2] = 18; oy[3] = 22;
      start_fetch(30);
      repeat (4) tick();
      start_fetch(22);
      for (int k = 0; k < 6; k++) begin
         draw_x = 10'(ox[0] + k);
         tick();
         check("busy_held", {31'd0, fetch_busy}, 1);
         check("display_held", {31'd0, is_mushroom}, {31'd0, model_hit(ox[0] + k)});
      end
      wait_swap(22, 7);
      sweep(0, 200, "after_restart");

      // Right-edge object does not wrap to x=0.
      clear_objs();
      ov[0] = 1; ox[0] = 1020; oy[0] = 300;
      fetch(300 + $urandom_range(0, 15));
      sweep(1012, 1023, "right_edge");
      sweep(0, 11, "no_wrap");

`ifdef MUSHROOM_FLIP_EN
      clear_objs();
      ov[0] = 1; ox[0] = 200; oy[0] = 400; ofl[0] = 1;
      fetch(405);
      draw_x = 10'd200;
      tick();
      check("flip_first_pixel", {31'd0, is_mushroom}, {31'd0, rom[5][0]});
      sweep(195, 220, "flip_line");
`endif

      // Randomized object tables, full-line sweeps.
      for (int it = 0; it < 6; it++) begin
         clear_objs();
         for (int k = 0; k < N; k++) begin
            ov[k] = ($urandom_range(0, 3) != 0);
            ox[k] = $urandom_range(0, 1023);
            oy[k] = $urandom_range(100, 130);
`ifdef MUSHROOM_FLIP_EN
            ofl[k] = $urandom_range(0, 1);
`endif
         end
         fetch($urandom_range(95, 150));
         sweep(0, 1023, "random_line");
      end

      // Reset in the middle of a fetch.
      clear_objs();
      for (int k = 0; k < 6; k++) begin
         ov[k] = 1; ox[k] = 20 * k; oy[k] = 500;
      end
      fetch(505);
      check("ovf_before_reset", {31'd0, line_ovf}, 1);
      draw_x = 10'd0;
      start_fetch(510);
      repeat (2) tick();
      Reset = 1'b1;
      tick();
      check("midrst_rom_addr", {28'd0, rom_addr}, 0);
      check("midrst_is_mushroom", {31'd0, is_mushroom}, 0);
      check("midrst_fetch_busy", {31'd0, fetch_busy}, 0);
      check("midrst_line_ovf", {31'd0, line_ovf}, 0);
      Reset = 1'b0;
      disp_ok = 0;
      sweep(0, 130, "cleared_display");
      fetch(510);
      sweep(0, 130, "post_reset_line");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
